booth4_seq_mult: RTL and testbench

BOOTH4_SEQ_MULT -- requirements
Module: booth4_seq_mult

---
 rtl/booth4_seq_mult.sv | 150 +++++++++++++++
 tb/tb_booth4_seq_mult.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/booth4_seq_mult.sv
// -----------------------------------------------------------------------------
// booth4_seq_mult
//
// Sequential signed multiplier using radix-4 Booth recoding. One Booth digit
// is retired per RUN cycle, so a WIDTH x WIDTH multiply takes WIDTH/2 RUN
// cycles followed by a single DONE cycle.
//
// Parameters
//   WIDTH         operand width in bits; must be even and >= 4
//
// Ports
//   clk           single clock, all state changes on the rising edge
//   rst           asynchronous active-high reset
//   start         begin a multiply; only looked at while idle
//   multiplicand  signed operand A, captured together with start
//   multiplier    signed operand B (Booth-recoded), captured with start
//   busy          high during the RUN cycles that follow the first digit
//   done          one-cycle pulse; product has just been updated
//   product       signed A*B, held until the next completion
// -----------------------------------------------------------------------------
module booth4_seq_mult #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int HALF = WIDTH / 2;
   localparam int PW   = 2 * WIDTH;
   localparam int CW   = $clog2(HALF) + 1;
   localparam logic [CW-1:0] LAST_DIGIT = CW'(HALF - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PW-1:0]      mcand_q, mcand_d;
   logic [WIDTH:0]     mplr_q, mplr_d;
   logic [PW-1:0]      acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [PW-1:0]      product_q, product_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [PW-1:0]      acc_sum;

   // Maps a 3-bit Booth grouping onto its partial product. The multiplicand
   // handed in is already sign-extended and aligned to the current digit, so
   // only the 0 / +-1 / +-2 selection happens here. All arithmetic wraps
   // modulo 2^PW, which keeps the -2^(WIDTH-1) squared case exact.
   function automatic logic [PW-1:0] booth_pp(input logic [2:0]    grp,
                                              input logic [PW-1:0] a);
      logic [PW-1:0] pp;
      case (grp)
         3'b001, 3'b010: pp = a;
         3'b011:         pp = a << 1;
         3'b100:         pp = -(a << 1);
         3'b101, 3'b110: pp = -a;
         default:        pp = '0;
      endcase
      return pp;
   endfunction

   // The multiplier is held as {B, 1'b0} so its low three bits are always the
   // current grouping with B[-1] = 0. Each RUN cycle it moves right by two
   // while the multiplicand moves left by two, which supplies the 2i weight
   // of each partial product without a variable shifter.
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      acc_sum   = acc_q + booth_pp(mplr_q[2:0], mcand_q);

      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d = {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
               mplr_d  = {multiplier, 1'b0};
               acc_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            acc_d   = acc_sum;
            mcand_d = mcand_q << 2;
            mplr_d  = mplr_q >> 2;
            if (cnt_q == LAST_DIGIT) begin
               product_d = acc_sum;
               done_d    = 1'b1;
               state_d   = DONE;
            end else begin
               cnt_d  = cnt_q + CW'(1);
               busy_d = 1'b1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Single state register for the FSM, datapath and registered outputs.
   // Reset clears everything, so an aborted operation leaves product at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplr_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplr_q    <= mplr_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_booth4_seq_mult.sv
// -----------------------------------------------------------------------------
// tb_booth4_seq_mult
//
// Scoreboard bench for booth4_seq_mult at WIDTH=16. The driver pushes the
// expected product and the expected completion cycle for every accepted
// start; an independent monitor pops and compares on every done pulse.
// The reference is plain signed integer multiplication.
// -----------------------------------------------------------------------------
module tb_booth4_seq_mult;

   localparam int W        = 16;
   localparam int HALF     = W / 2;
   localparam int N_RANDOM = 6000;

   typedef struct {
      logic [2*W-1:0] prod;
      int             doneCyc;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             start;
   logic [W-1:0]     multiplicand;
   logic [W-1:0]     multiplier;
   logic             busy;
   logic             done;
   logic [2*W-1:0]   product;

   exp_t             sbQ[$];
   int               checks;
   int               errors;
   int               cyc;
   logic [2*W-1:0]   heldExp;

   booth4_seq_mult #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   // Free-running clock plus an edge counter used to time completions.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   // Reference model: exact signed product truncated to 2*W bits.
   function automatic logic [2*W-1:0] refMul(input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      longint pa, pb, p;
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      p  = pa * pb;
      return p[2*W-1:0];
   endfunction

   // Mostly uniform operands, with extremes mixed in regularly.
   function automatic logic [W-1:0] pickOperand();
      logic [31:0] r;
      int sel;
      sel = $urandom_range(0, 9);
      r   = $urandom;
      case (sel)
         0:       return 16'h8000;
         1:       return 16'h7FFF;
         2:       return 16'hFFFF;
         3:       return 16'h0000;
         4:       return 16'h0001;
         default: return r[W-1:0];
      endcase
   endfunction

   // One comparison: counted, and reported only when it fails.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at cycle %0d",
                  name, actual, expected, cyc);
      end
   endtask

   // Issues one multiply and follows it through to its DONE cycle, checking
   // busy timing and that product holds its previous value while running.
   // A second start with A=B=9 is pulsed at relative cycle restartAt when it
   // is non-negative; it must be ignored.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input int restartAt);
      exp_t e;
      logic [31:0] r;
      @(negedge clk);
      start        = 1'b1;
      multiplicand = a;
      multiplier   = b;
      e.prod       = refMul(a, b);
      e.doneCyc    = cyc + 1 + HALF;
      sbQ.push_back(e);
      @(posedge clk);
      #1;
      start        = 1'b0;
      r            = $urandom;
      multiplicand = r[W-1:0];
      multiplier   = r[2*W-1:W];
      for (int j = 0; j <= HALF; j++) begin
         @(negedge clk);
         start = 1'b0;
         checkOutput("busy", 64'(busy), 64'((j >= 1 && j <= HALF - 1) ? 1 : 0));
         if (j < HALF)
            checkOutput("productHeld", 64'(product), 64'(heldExp));
         if (j == restartAt) begin
            start        = 1'b1;
            multiplicand = 16'd9;
            multiplier   = 16'd9;
         end
      end
      start   = 1'b0;
      heldExp = e.prod;
   endtask

   // Monitor: every done pulse must match the oldest outstanding request,
   // both in value and in the cycle it appears.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         if (sbQ.size() == 0) begin
            checkOutput("spuriousDone", 64'(1), 64'(0));
         end else begin
            e = sbQ.pop_front();
            checkOutput("product", 64'(product), 64'(e.prod));
            checkOutput("doneCycle", 64'(cyc), 64'(e.doneCyc));
         end
      end
   end

   initial begin
      checks       = 0;
      errors       = 0;
      heldExp      = '0;
      rst          = 1'b0;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;

      // Asynchronous reset: outputs must clear before any clock edge.
      #2 rst = 1'b1;
      #1;
      checkOutput("resetBusy", 64'(busy), 64'(0));
      checkOutput("resetDone", 64'(done), 64'(0));
      checkOutput("resetProduct", 64'(product), 64'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Directed values.
      applyStimulus(16'd3, 16'd5, -1);
      applyStimulus(16'h8000, 16'h8000, -1);
      applyStimulus(16'h7FFF, 16'hFFFF, -1);
      applyStimulus(16'h1234, 16'h0004, -1);

      // Second start during RUN must be dropped, not queued.
      applyStimulus(16'h0123, 16'h0456, 3);
      repeat (HALF + 2) begin
         @(negedge clk);
         checkOutput("idleBusy", 64'(busy), 64'(0));
      end

      // Reset four cycles into RUN aborts the operation.
      @(negedge clk);
      start        = 1'b1;
      multiplicand = 16'd100;
      multiplier   = 16'hFFFD;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("abortBusy", 64'(busy), 64'(0));
      checkOutput("abortDone", 64'(done), 64'(0));
      checkOutput("abortProduct", 64'(product), 64'(0));
      @(negedge clk);
      rst     = 1'b0;
      heldExp = '0;
      repeat (HALF + 2) begin
         @(negedge clk);
         checkOutput("abortIdle", 64'(busy), 64'(0));
      end
      applyStimulus(16'hFFF9, 16'd6, -1);

      // Random back-to-back operations at full throughput.
      for (int n = 0; n < N_RANDOM; n++)
         applyStimulus(pickOperand(), pickOperand(), -1);

      // Drain with a bounded wait.
      for (int t = 0; t < 50 && sbQ.size() != 0; t++)
         @(negedge clk);
      checkOutput("drained", 64'(sbQ.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
